// File: rtl/fsm_tbl_pkg.sv
// Shared widths, rule record layout and the rule-match predicate for the table-driven FSM engine.
package fsm_tbl_pkg;
    localparam int N_IN    = 12;
    localparam int N_OUT   = 10;
    localparam int STATE_W = 3;
    localparam int N_RULES = 16;
    localparam int CNT_W   = 8;
    localparam int IDX_W   = $clog2(N_RULES);

    localparam int                 DEF_N_STATES    = 8;
    localparam logic [STATE_W-1:0] DEF_RESET_STATE = 3'd1;

    typedef struct packed {
        logic               valid;
        logic [STATE_W-1:0] state;
        logic [N_IN-1:0]    care;
        logic [N_IN-1:0]    val;
        logic [STATE_W-1:0] next;
        logic [N_OUT-1:0]   out;
    } rule_t;

    // Only the bits selected by care are compared against val.
    function automatic logic rule_matches(input rule_t r, input logic [STATE_W-1:0] s,
                                          input logic [N_IN-1:0] x);
        return r.valid && (r.state == s) && (((x ^ r.val) & r.care) == {N_IN{1'b0}});
    endfunction
endpackage

// File: rtl/fsm_rule_match.sv
// Parallel rule comparators followed by a lowest-index-wins priority encoder.
module fsm_rule_match
    import fsm_tbl_pkg::*;
(
    input  rule_t              rules [N_RULES],
    input  logic [STATE_W-1:0] state,
    input  logic [N_IN-1:0]    x,
    output logic               hit,
    output logic [IDX_W-1:0]   hit_idx
);
    logic [N_RULES-1:0] match_s;

    // One comparator per rule
    always_comb begin
        match_s = {N_RULES{1'b0}};
        for (int r = 0; r < N_RULES; r++) begin
            match_s[r] = rule_matches(rules[r], state, x);
        end
    end

    // Scan downward so the lowest matching index is the last one written
    always_comb begin
        hit     = 1'b0;
        hit_idx = {IDX_W{1'b0}};
        for (int r = N_RULES - 1; r >= 0; r--) begin
            hit     = hit | match_s[r];
            hit_idx = match_s[r] ? IDX_W'(r) : hit_idx;
        end
    end
endmodule

// File: rtl/fsm_table_engine.sv
// Programmable Mealy controller: rule table, state register, step/dwell counters,
// dwell watchdog and illegal-state recovery.
module fsm_table_engine
    import fsm_tbl_pkg::*;
#(
    parameter int                 N_STATES    = DEF_N_STATES,
    parameter logic [STATE_W-1:0] RESET_STATE = DEF_RESET_STATE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [N_IN-1:0]    x,
    output logic [N_OUT-1:0]   y,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic               cfg_valid,
    input  logic [STATE_W-1:0] cfg_state,
    input  logic [N_IN-1:0]    cfg_care,
    input  logic [N_IN-1:0]    cfg_val,
    input  logic [STATE_W-1:0] cfg_next,
    input  logic [N_OUT-1:0]   cfg_out,
    output logic               cfg_err,
    output logic [STATE_W-1:0] state,
    output logic               hit,
    output logic [IDX_W-1:0]   hit_idx,
    output logic [CNT_W-1:0]   step_cnt,
    input  logic [CNT_W-1:0]   dwell_lim,
    output logic               dwell_to,
    output logic               illegal
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    rule_t              rules_r [N_RULES];
    logic               bad_state_s;
    logic [STATE_W-1:0] next_state_s;
    logic [CNT_W-1:0]   dwell_r;
    logic [CNT_W-1:0]   dwell_nx_s;

    fsm_rule_match u_match (
        .rules   (rules_r),
        .state   (state),
        .x       (x),
        .hit     (hit),
        .hit_idx (hit_idx)
    );

    assign bad_state_s  = int'(state) >= N_STATES;
    assign next_state_s = rules_r[hit_idx].next;

    // Mealy output of the winning rule, suppressed while frozen or in reset
    always_comb begin
        if (!rst && run && hit) begin
            y = rules_r[hit_idx].out;
        end else begin
            y = {N_OUT{1'b0}};
        end
    end

    // Dwell restarts on a real state change; self-loops keep counting
    always_comb begin
        if (bad_state_s) begin
            dwell_nx_s = {CNT_W{1'b0}};
        end else if (run && hit && (next_state_s != state)) begin
            dwell_nx_s = {CNT_W{1'b0}};
        end else if (run && (dwell_r != CNT_MAX)) begin
            dwell_nx_s = dwell_r + CNT_W'(1);
        end else begin
            dwell_nx_s = dwell_r;
        end
    end

    // State, counters, watchdog, status pulses and config write path
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RESET_STATE;
            step_cnt <= {CNT_W{1'b0}};
            dwell_r  <= {CNT_W{1'b0}};
            dwell_to <= 1'b0;
            cfg_err  <= 1'b0;
            illegal  <= 1'b0;
            for (int r = 0; r < N_RULES; r++) begin
                rules_r[r].valid <= 1'b0;
            end
        end else begin
            cfg_err  <= cfg_we & run;
            illegal  <= bad_state_s;
            dwell_r  <= dwell_nx_s;
            dwell_to <= dwell_to | ((dwell_lim != {CNT_W{1'b0}}) && (dwell_nx_s == dwell_lim));
            if (cfg_we && !run && (int'(cfg_idx) < N_RULES)) begin
                rules_r[cfg_idx] <= '{valid: cfg_valid, state: cfg_state, care: cfg_care,
                                      val: cfg_val, next: cfg_next, out: cfg_out};
            end
            // Recovery from an upset state takes precedence over stepping, even when frozen
            if (bad_state_s) begin
                state <= RESET_STATE;
            end else if (run && hit) begin
                state <= next_state_s;
                if (step_cnt != CNT_MAX) begin
                    step_cnt <= step_cnt + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_fsm_table_engine.sv
// Self-checking bench for fsm_table_engine: directed table, corner sequences and random traffic
// checked against a behavioural model of the rule semantics.
module tb_fsm_table_engine;
    import fsm_tbl_pkg::*;

    localparam int NS = 7;

    logic               clk = 1'b0;
    logic               rst, run, cfg_we, cfg_valid;
    logic [N_IN-1:0]    x, cfg_care, cfg_val;
    logic [IDX_W-1:0]   cfg_idx, hit_idx;
    logic [STATE_W-1:0] cfg_state, cfg_next, state;
    logic [N_OUT-1:0]   cfg_out, y;
    logic               cfg_err, hit, dwell_to, illegal;
    logic [CNT_W-1:0]   step_cnt, dwell_lim;

    int n_cmp = 0;
    int n_bad = 0;

    // behavioural model
    bit mv [N_RULES];
    int ms [N_RULES], mc [N_RULES], mval [N_RULES], mnx [N_RULES], mout [N_RULES];
    int m_st, m_step, m_dwell;
    bit m_to, m_err, m_ill, m_init = 1'b0;

    typedef struct {
        logic               run;
        logic [N_IN-1:0]    x;
        logic               hit_e;
        logic [IDX_W-1:0]   idx_e;
        logic [N_OUT-1:0]   y_e;
        logic [STATE_W-1:0] st_e;
        logic [CNT_W-1:0]   step_e;
    } vec_t;
    vec_t vt [7];

    fsm_table_engine #(.N_STATES(NS), .RESET_STATE(3'd1)) dut (
        .clk(clk), .rst(rst), .run(run), .x(x), .y(y),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_valid(cfg_valid), .cfg_state(cfg_state),
        .cfg_care(cfg_care), .cfg_val(cfg_val), .cfg_next(cfg_next), .cfg_out(cfg_out),
        .cfg_err(cfg_err), .state(state), .hit(hit), .hit_idx(hit_idx), .step_cnt(step_cnt),
        .dwell_lim(dwell_lim), .dwell_to(dwell_to), .illegal(illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int m_win(input logic [N_IN-1:0] xx);
        for (int r = 0; r < N_RULES; r++) begin
            if (mv[r] && ms[r] == m_st && ((int'(xx) ^ mval[r]) & mc[r]) == 0) return r;
        end
        return -1;
    endfunction

    task automatic m_update();
        int w, nst;
        bit bad;
        if (rst) begin
            m_init = 1'b1; m_st = 1; m_step = 0; m_dwell = 0;
            m_to = 1'b0; m_err = 1'b0; m_ill = 1'b0;
            for (int r = 0; r < N_RULES; r++) mv[r] = 1'b0;
        end else begin
            w = m_win(x);
            bad = (m_st >= NS);
            m_err = cfg_we && run;
            m_ill = bad;
            if (cfg_we && !run) begin
                mv[cfg_idx] = cfg_valid; ms[cfg_idx] = int'(cfg_state); mc[cfg_idx] = int'(cfg_care);
                mval[cfg_idx] = int'(cfg_val); mnx[cfg_idx] = int'(cfg_next); mout[cfg_idx] = int'(cfg_out);
            end
            if (bad) begin
                m_st = 1; m_dwell = 0;
            end else if (run) begin
                nst = (w >= 0) ? mnx[w] : m_st;
                if (w >= 0) m_step = (m_step < 255) ? m_step + 1 : 255;
                m_dwell = (nst != m_st) ? 0 : ((m_dwell < 255) ? m_dwell + 1 : 255);
                m_st = nst;
            end
            if (dwell_lim != 0 && m_dwell == int'(dwell_lim)) m_to = 1'b1;
        end
    endtask

    // One clock: comb checks before the edge, registered checks after it; returns at negedge.
    task automatic tick();
        int w;
        #1;
        if (m_init) begin
            w = m_win(x);
            chk("m_hit", hit, w >= 0);
            chk("m_hit_idx", hit_idx, (w >= 0) ? w : 0);
            chk("m_y", y, (!rst && run && w >= 0) ? mout[w] : 0);
        end
        @(posedge clk);
        m_update();
        #1;
        chk("m_state", state, m_st);
        chk("m_step_cnt", step_cnt, m_step);
        chk("m_dwell_to", dwell_to, m_to);
        chk("m_illegal", illegal, m_ill);
        chk("m_cfg_err", cfg_err, m_err);
        @(negedge clk);
    endtask

    task automatic prog(input int idx, input int st, input int care, input int val,
                        input int nx, input int out);
        cfg_we = 1'b1; run = 1'b0; cfg_idx = IDX_W'(idx); cfg_valid = 1'b1;
        cfg_state = STATE_W'(st); cfg_care = N_IN'(care); cfg_val = N_IN'(val);
        cfg_next = STATE_W'(nx); cfg_out = N_OUT'(out);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; cfg_we = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        vt[0] = '{1'b1, 12'h003, 1'b1, 4'd0, 10'h008, 3'd3, 8'd1};
        vt[1] = '{1'b1, 12'h000, 1'b1, 4'd2, 10'h2AA, 3'd2, 8'd2};
        vt[2] = '{1'b1, 12'h004, 1'b0, 4'd0, 10'h000, 3'd2, 8'd2};
        vt[3] = '{1'b0, 12'h005, 1'b1, 4'd3, 10'h000, 3'd2, 8'd2};
        vt[4] = '{1'b1, 12'hFF5, 1'b1, 4'd3, 10'h155, 3'd1, 8'd3};
        vt[5] = '{1'b1, 12'h001, 1'b1, 4'd1, 10'h011, 3'd4, 8'd4};
        vt[6] = '{1'b1, 12'h000, 1'b0, 4'd0, 10'h000, 3'd4, 8'd4};

        rst = 1'b1; run = 1'b0; x = '0; cfg_we = 1'b0; cfg_idx = '0; cfg_valid = 1'b0;
        cfg_state = '0; cfg_care = '0; cfg_val = '0; cfg_next = '0; cfg_out = '0; dwell_lim = '0;
        @(negedge clk);

        // reset state and first programmed transition
        do_reset();
        chk("rst_state", state, 1);
        chk("rst_step", step_cnt, 0);
        chk("rst_flags", {dwell_to, illegal, cfg_err}, 0);
        prog(0, 1, 12'h002, 12'h002, 2, 10'h008);
        run = 1'b1; x = 12'h002;
        #1 chk("t1_y", y, 10'h008);
        tick();
        chk("t1_state", state, 2);
        chk("t1_step", step_cnt, 1);

        // directed table: priority, don't-care bits, run=0 gating
        do_reset();
        prog(0, 1, 12'h002, 12'h002, 3, 10'h008);
        prog(1, 1, 12'h001, 12'h001, 4, 10'h011);
        prog(2, 3, 12'h000, 12'h000, 2, 10'h2AA);
        prog(3, 2, 12'h00F, 12'h005, 1, 10'h155);
        for (int i = 0; i < 7; i++) begin
            run = vt[i].run; x = vt[i].x;
            #1;
            chk($sformatf("vec%0d_hit", i), hit, vt[i].hit_e);
            chk($sformatf("vec%0d_idx", i), hit_idx, vt[i].idx_e);
            chk($sformatf("vec%0d_y", i), y, vt[i].y_e);
            tick();
            chk($sformatf("vec%0d_state", i), state, vt[i].st_e);
            chk($sformatf("vec%0d_step", i), step_cnt, vt[i].step_e);
        end

        // dwell watchdog in a state with no outgoing rules
        do_reset();
        dwell_lim = 8'd5;
        prog(0, 1, 0, 0, 4, 10'h3FF);
        run = 1'b1; x = 12'h000;
        tick();
        for (int k = 1; k <= 10; k++) begin
            x = N_IN'($urandom);
            #1 chk($sformatf("dw%0d_y", k), y, 0);
            tick();
            chk($sformatf("dw%0d_state", k), state, 4);
            chk($sformatf("dw%0d_to", k), dwell_to, k >= 5);
        end

        // config write while running is dropped and flagged
        cfg_we = 1'b1; cfg_idx = 4'd1; cfg_valid = 1'b1; cfg_state = 3'd4; cfg_care = '0;
        cfg_next = 3'd1; cfg_out = 10'h123; run = 1'b1;
        tick();
        chk("cfgerr_pulse", cfg_err, 1);
        cfg_we = 1'b0;
        #1 chk("cfgerr_nowrite_hit", hit, 0);
        tick();
        chk("cfgerr_clear", cfg_err, 0);
        chk("cfgerr_state", state, 4);

        // illegal state recovery, even with run low
        do_reset();
        prog(0, 1, 0, 0, 7, 10'h001);
        run = 1'b1;
        tick();
        chk("ill_enter", state, 7);
        chk("ill_nopulse", illegal, 0);
        run = 1'b0;
        tick();
        chk("ill_recover", state, 1);
        chk("ill_pulse", illegal, 1);
        tick();
        chk("ill_pulse_end", illegal, 0);

        // step counter saturation on a self-loop, then reset mid-run
        do_reset();
        prog(0, 1, 0, 0, 2, 10'h001);
        prog(1, 2, 0, 0, 2, 10'h0AA);
        run = 1'b1;
        for (int k = 0; k < 300; k++) begin
            x = N_IN'($urandom);
            tick();
        end
        chk("sat_step", step_cnt, 255);
        chk("sat_state", state, 2);
        rst = 1'b1;
        #1 chk("rst_y_zero", y, 0);
        tick();
        chk("midrst_state", state, 1);
        chk("midrst_step", step_cnt, 0);
        rst = 1'b0;
        #1 chk("midrst_rules_clear", hit, 0);
        tick();

        // randomized traffic against the model
        do_reset();
        for (int r = 0; r < N_RULES; r++) begin
            prog(r, $urandom_range(0, 6), $urandom & $urandom & $urandom, $urandom,
                 ($urandom_range(0, 19) == 0) ? 7 : $urandom_range(0, 6), $urandom);
        end
        for (int k = 0; k < 3000; k++) begin
            rst       = ($urandom_range(0, 299) == 0);
            run       = ($urandom_range(0, 4) != 0);
            cfg_we    = ($urandom_range(0, 3) == 0);
            cfg_idx   = IDX_W'($urandom);
            cfg_valid = ($urandom_range(0, 3) != 0);
            cfg_state = STATE_W'($urandom_range(0, 6));
            cfg_care  = N_IN'($urandom & $urandom & $urandom);
            cfg_val   = N_IN'($urandom);
            cfg_next  = STATE_W'(($urandom_range(0, 29) == 0) ? 7 : $urandom_range(0, 6));
            cfg_out   = N_OUT'($urandom);
            dwell_lim = CNT_W'($urandom_range(0, 12));
            x         = N_IN'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
